// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcode/funct encodings, ALU selects and the
// ID/EX control bundle carried from decode into execute.
package pipe_pkg;

    localparam int REG_ADDR_W = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b100
    } alu_op_t;

    typedef struct packed {
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    mem_to_reg;
        logic    alu_src;
        logic    reg_dst;
        logic    branch;
        logic    jump;
        alu_op_t alu_op;
    } id_ex_ctrl_t;

    // A bubble is a no-op in every later stage: nothing written, nothing stored.
    localparam id_ex_ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/reg_file.sv
// 32x32 register file: two combinational read ports with write-first bypass,
// one synchronous write port, r0 hardwired to zero, synchronous reset.
module reg_file
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    output logic [DATA_W-1:0] data_a,
    output logic [DATA_W-1:0] data_b,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && wr_addr != '0) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Bypass lets an instruction in decode see the value being written back
    // on the same edge, so WB->ID needs no extra stall.
    always_comb begin
        data_a = regs[addr_a];
        if (addr_a == '0) begin
            data_a = '0;
        end else if (we && addr_a == wr_addr) begin
            data_a = wr_data;
        end
    end

    always_comb begin
        data_b = regs[addr_b];
        if (addr_b == '0) begin
            data_b = '0;
        end else if (we && addr_b == wr_addr) begin
            data_b = wr_data;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// MIPS instruction-decode stage: control decode, register read/writeback,
// immediate sign extension, load-use hazard detection and the ID/EX register.
module decode_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instruction,
    input  logic [31:0]       pc_in,
    input  logic              wb_we,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic              stall,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] imm_ext,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [31:0]       pc_out,
    output logic [15:0]       b_address,
    output logic [25:0]       j_address,
    output logic              reg_write,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_to_reg,
    output logic              alu_src,
    output logic              reg_dst,
    output logic              branch,
    output logic              jump,
    output logic [2:0]        alu_op
);

    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [4:0]        rs_field;
    logic [4:0]        rt_field;
    logic [4:0]        rd_field;
    logic [15:0]       imm_field;
    logic [DATA_W-1:0] read_a;
    logic [DATA_W-1:0] read_b;
    logic [DATA_W-1:0] imm_sext;
    logic              reads_rt;
    id_ex_ctrl_t       dec_ctrl;
    id_ex_ctrl_t       ctrl_q;

    assign opcode    = instruction[31:26];
    assign rs_field  = instruction[25:21];
    assign rt_field  = instruction[20:16];
    assign rd_field  = instruction[15:11];
    assign imm_field = instruction[15:0];
    assign funct     = instruction[5:0];
    assign imm_sext  = {{(DATA_W-16){imm_field[15]}}, imm_field};

    reg_file #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .ADDR_W (REG_ADDR_W)
    ) u_reg_file (
        .clk     (clk),
        .rst     (rst),
        .addr_a  (rs_field),
        .addr_b  (rt_field),
        .data_a  (read_a),
        .data_b  (read_b),
        .we      (wb_we),
        .wr_addr (wb_addr),
        .wr_data (wb_data)
    );

    // Unknown opcodes and unknown R-type functs decode to a bubble.
    always_comb begin
        dec_ctrl = CTRL_BUBBLE;
        case (opcode)
            OP_RTYPE: begin
                dec_ctrl.reg_dst   = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                case (funct)
                    FUNCT_ADD: dec_ctrl.alu_op = ALU_ADD;
                    FUNCT_SUB: dec_ctrl.alu_op = ALU_SUB;
                    FUNCT_AND: dec_ctrl.alu_op = ALU_AND;
                    FUNCT_OR:  dec_ctrl.alu_op = ALU_OR;
                    FUNCT_SLT: dec_ctrl.alu_op = ALU_SLT;
                    default:   dec_ctrl        = CTRL_BUBBLE;
                endcase
            end
            OP_LW: begin
                dec_ctrl.alu_src    = 1'b1;
                dec_ctrl.mem_read   = 1'b1;
                dec_ctrl.mem_to_reg = 1'b1;
                dec_ctrl.reg_write  = 1'b1;
                dec_ctrl.alu_op     = ALU_ADD;
            end
            OP_SW: begin
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.mem_write = 1'b1;
                dec_ctrl.alu_op    = ALU_ADD;
            end
            OP_BEQ: begin
                dec_ctrl.branch = 1'b1;
                dec_ctrl.alu_op = ALU_SUB;
            end
            OP_ADDI: begin
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_op    = ALU_ADD;
            end
            OP_J: begin
                dec_ctrl.jump = 1'b1;
            end
            default: begin
                dec_ctrl = CTRL_BUBBLE;
            end
        endcase
    end

    // Only formats that actually read rt as a source can hazard on it.
    assign reads_rt = (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);

    assign stall = ctrl_q.mem_read && (rt != '0) &&
                   ((rt == rs_field) || ((rt == rt_field) && reads_rt)) &&
                   !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q    <= CTRL_BUBBLE;
            rs_data   <= '0;
            rt_data   <= '0;
            imm_ext   <= '0;
            rs        <= '0;
            rt        <= '0;
            rd        <= '0;
            pc_out    <= '0;
            b_address <= '0;
            j_address <= '0;
        end else begin
            ctrl_q    <= (flush || stall) ? CTRL_BUBBLE : dec_ctrl;
            rs_data   <= read_a;
            rt_data   <= read_b;
            imm_ext   <= imm_sext;
            rs        <= rs_field;
            rt        <= rt_field;
            rd        <= rd_field;
            pc_out    <= pc_in;
            b_address <= imm_field;
            j_address <= instruction[25:0];
        end
    end

    assign reg_write  = ctrl_q.reg_write;
    assign mem_read   = ctrl_q.mem_read;
    assign mem_write  = ctrl_q.mem_write;
    assign mem_to_reg = ctrl_q.mem_to_reg;
    assign alu_src    = ctrl_q.alu_src;
    assign reg_dst    = ctrl_q.reg_dst;
    assign branch     = ctrl_q.branch;
    assign jump       = ctrl_q.jump;
    assign alu_op     = ctrl_q.alu_op;

endmodule

// File: tb/tb_decode_stage.sv
// Directed-vector bench for decode_stage; control bits are checked as one
// byte {reg_write,mem_read,mem_write,mem_to_reg,alu_src,reg_dst,branch,jump}.
module tb_decode_stage;

    logic        clk;
    logic        rst;
    logic [31:0] instruction;
    logic [31:0] pc_in;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        flush;
    logic        stall;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm_ext;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] pc_out;
    logic [15:0] b_address;
    logic [25:0] j_address;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        alu_src;
    logic        reg_dst;
    logic        branch;
    logic        jump;
    logic [2:0]  alu_op;

    int checksDone;
    int checksPassed;

    decode_stage #(
        .DATA_W (32),
        .NREGS  (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instruction (instruction),
        .pc_in       (pc_in),
        .wb_we       (wb_we),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .flush       (flush),
        .stall       (stall),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .imm_ext     (imm_ext),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .pc_out      (pc_out),
        .b_address   (b_address),
        .j_address   (j_address),
        .reg_write   (reg_write),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_to_reg  (mem_to_reg),
        .alu_src     (alu_src),
        .reg_dst     (reg_dst),
        .branch      (branch),
        .jump        (jump),
        .alu_op      (alu_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ctrlByte();
        return {24'h0, reg_write, mem_read, mem_write, mem_to_reg,
                alu_src, reg_dst, branch, jump};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checksDone++;
        if (observed === expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got %h, want %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc,
                                 input logic we, input logic [4:0] waddr,
                                 input logic [31:0] wdata, input logic fl);
        instruction = instr;
        pc_in       = pc;
        wb_we       = we;
        wb_addr     = waddr;
        wb_data     = wdata;
        flush       = fl;
        #1;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ctrl"}, ctrlByte(), 32'h0);
        checkOutput({tag, "_aluop"}, {29'h0, alu_op}, 32'h0);
        checkOutput({tag, "_rsdata"}, rs_data, 32'h0);
        checkOutput({tag, "_rtdata"}, rt_data, 32'h0);
        checkOutput({tag, "_imm"}, imm_ext, 32'h0);
        checkOutput({tag, "_fields"}, {17'h0, rs, rt, rd}, 32'h0);
        checkOutput({tag, "_pc"}, pc_out, 32'h0);
        checkOutput({tag, "_jaddr"}, {6'h0, j_address}, 32'h0);
        checkOutput({tag, "_baddr"}, {16'h0, b_address}, 32'h0);
        checkOutput({tag, "_stall"}, {31'h0, stall}, 32'h0);
    endtask

    initial begin
        checksDone   = 0;
        checksPassed = 0;

        // Reset with a pending write that must be discarded
        rst = 1'b1;
        applyStimulus(32'h8C080004, 32'h0000_0040, 1'b1, 5'd8, 32'hDEAD_BEEF, 1'b0);
        stepClock();
        stepClock();
        checkAllZero("reset");
        rst = 1'b0;

        // sll-like all-zero word: unknown funct -> bubble
        applyStimulus(32'h00000000, 32'h0000_0100, 1'b0, 5'd0, 32'h0, 1'b0);
        checkOutput("nop_stall", {31'h0, stall}, 32'h0);
        stepClock();
        checkOutput("nop_ctrl", ctrlByte(), 32'h0);
        checkOutput("nop_rsdata", rs_data, 32'h0);
        checkOutput("nop_pc", pc_out, 32'h0000_0100);

        // add r10,r8,r9 with simultaneous WB r8=0x1234 (bypass)
        applyStimulus(32'h01095020, 32'h0000_0104, 1'b1, 5'd8, 32'h0000_1234, 1'b0);
        checkOutput("add_stall", {31'h0, stall}, 32'h0);
        stepClock();
        checkOutput("add_rsdata", rs_data, 32'h0000_1234);
        checkOutput("add_rtdata", rt_data, 32'h0);
        checkOutput("add_ctrl", ctrlByte(), 32'h84);
        checkOutput("add_aluop", {29'h0, alu_op}, 32'h0);
        checkOutput("add_fields", {17'h0, rs, rt, rd}, {17'h0, 5'd8, 5'd9, 5'd10});
        checkOutput("add_pc", pc_out, 32'h0000_0104);

        // sub r11,r8,r0: r8 read from storage; WB r9=0x55
        applyStimulus(32'h01005822, 32'h0000_0108, 1'b1, 5'd9, 32'h0000_0055, 1'b0);
        stepClock();
        checkOutput("sub_rsdata", rs_data, 32'h0000_1234);
        checkOutput("sub_aluop", {29'h0, alu_op}, 32'h1);
        checkOutput("sub_rd", {27'h0, rd}, 32'd11);

        // lw r8,4(r0)
        applyStimulus(32'h8C080004, 32'h0000_010C, 1'b0, 5'd0, 32'h0, 1'b0);
        checkOutput("lw_stall_pre", {31'h0, stall}, 32'h0);
        stepClock();
        checkOutput("lw_ctrl", ctrlByte(), 32'hD8);
        checkOutput("lw_imm", imm_ext, 32'h0000_0004);
        checkOutput("lw_rt", {27'h0, rt}, 32'd8);

        // add r10,r8,r9 right behind lw r8: one-cycle stall
        applyStimulus(32'h01095020, 32'h0000_0110, 1'b0, 5'd0, 32'h0, 1'b0);
        checkOutput("luse_stall", {31'h0, stall}, 32'h1);
        stepClock();
        checkOutput("luse_bubble_ctrl", ctrlByte(), 32'h0);
        checkOutput("luse_stall_clear", {31'h0, stall}, 32'h0);
        stepClock();
        checkOutput("luse_add_ctrl", ctrlByte(), 32'h84);
        checkOutput("luse_add_rtdata", rt_data, 32'h0000_0055);

        // lw r8 then addi r9,r0,5: no dependency
        applyStimulus(32'h8C080004, 32'h0000_0114, 1'b0, 5'd0, 32'h0, 1'b0);
        stepClock();
        applyStimulus(32'h20090005, 32'h0000_0118, 1'b0, 5'd0, 32'h0, 1'b0);
        checkOutput("addi_stall", {31'h0, stall}, 32'h0);
        stepClock();
        checkOutput("addi_imm", imm_ext, 32'h0000_0005);
        checkOutput("addi_ctrl", ctrlByte(), 32'h88);

        // lw r9 then sw r9,8(r8): rt dependency on a store stalls
        applyStimulus(32'h8C090000, 32'h0000_011C, 1'b0, 5'd0, 32'h0, 1'b0);
        stepClock();
        applyStimulus(32'hAD090008, 32'h0000_0120, 1'b0, 5'd0, 32'h0, 1'b0);
        checkOutput("sw_stall", {31'h0, stall}, 32'h1);
        stepClock();
        checkOutput("sw_stall_clear", {31'h0, stall}, 32'h0);
        stepClock();
        checkOutput("sw_ctrl", ctrlByte(), 32'h28);

        // beq r1,r2,-2 then same beq flushed
        applyStimulus(32'h1022FFFE, 32'h0000_0124, 1'b0, 5'd0, 32'h0, 1'b0);
        stepClock();
        checkOutput("beq_imm", imm_ext, 32'hFFFF_FFFE);
        checkOutput("beq_ctrl", ctrlByte(), 32'h02);
        checkOutput("beq_aluop", {29'h0, alu_op}, 32'h1);
        checkOutput("beq_baddr", {16'h0, b_address}, 32'h0000_FFFE);
        applyStimulus(32'h1022FFFE, 32'h0000_0128, 1'b0, 5'd0, 32'h0, 1'b1);
        stepClock();
        checkOutput("beqflush_ctrl", ctrlByte(), 32'h0);
        checkOutput("beqflush_aluop", {29'h0, alu_op}, 32'h0);

        // flush together with a load-use hazard: bubble but no stall
        applyStimulus(32'h8C080004, 32'h0000_012C, 1'b0, 5'd0, 32'h0, 1'b0);
        stepClock();
        applyStimulus(32'h01095020, 32'h0000_0130, 1'b0, 5'd0, 32'h0, 1'b1);
        checkOutput("flushhaz_stall", {31'h0, stall}, 32'h0);
        stepClock();
        checkOutput("flushhaz_ctrl", ctrlByte(), 32'h0);

        // j 0x10
        applyStimulus(32'h08000010, 32'h0000_0134, 1'b0, 5'd0, 32'h0, 1'b0);
        stepClock();
        checkOutput("j_ctrl", ctrlByte(), 32'h01);
        checkOutput("j_addr", {6'h0, j_address}, 32'h0000_0010);

        // and/or/slt r1,r2,r3 with WB r3=0xA5
        applyStimulus(32'h00430824, 32'h0000_0138, 1'b1, 5'd3, 32'h0000_00A5, 1'b0);
        stepClock();
        checkOutput("and_aluop", {29'h0, alu_op}, 32'h2);
        checkOutput("and_rtdata", rt_data, 32'h0000_00A5);
        applyStimulus(32'h00430825, 32'h0000_013C, 1'b0, 5'd0, 32'h0, 1'b0);
        stepClock();
        checkOutput("or_aluop", {29'h0, alu_op}, 32'h3);
        applyStimulus(32'h0043082A, 32'h0000_0140, 1'b0, 5'd0, 32'h0, 1'b0);
        stepClock();
        checkOutput("slt_aluop", {29'h0, alu_op}, 32'h4);
        checkOutput("slt_ctrl", ctrlByte(), 32'h84);

        // unknown opcode -> bubble
        applyStimulus(32'hFC000000, 32'h0000_0144, 1'b0, 5'd0, 32'h0, 1'b0);
        stepClock();
        checkOutput("badop_ctrl", ctrlByte(), 32'h0);

        // Writes to r0 are ignored, including the bypass path
        applyStimulus(32'h00005020, 32'h0000_0148, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0);
        stepClock();
        checkOutput("r0_bypass", rs_data, 32'h0);
        applyStimulus(32'h00005020, 32'h0000_014C, 1'b0, 5'd0, 32'h0, 1'b0);
        stepClock();
        checkOutput("r0_read", rs_data, 32'h0);

        // Reset mid-stream with a WB r5 in flight
        rst = 1'b1;
        applyStimulus(32'h8C080004, 32'h0000_0150, 1'b1, 5'd5, 32'h0000_0077, 1'b0);
        stepClock();
        checkAllZero("midrst");
        rst = 1'b0;

        // Registers were cleared and the in-flight write was dropped
        applyStimulus(32'h01095020, 32'h0000_0154, 1'b0, 5'd0, 32'h0, 1'b0);
        stepClock();
        checkOutput("postrst_r8", rs_data, 32'h0);
        checkOutput("postrst_r9", rt_data, 32'h0);
        applyStimulus(32'h00A00820, 32'h0000_0158, 1'b0, 5'd0, 32'h0, 1'b0);
        stepClock();
        checkOutput("postrst_r5", rs_data, 32'h0);

        $display("%0d/%0d checks passed", checksPassed, checksDone);
        $finish;
    end

endmodule
